// File: rtl/buf_spi_drain_pkg.sv
// rtl/buf_spi_drain_pkg.sv - shared widths and FSM encoding for the buffer SPI drain
package buf_spi_drain_pkg;

  localparam int FSMC_WIDTH     = 8;
  localparam int SPI_WIDHT      = 8;
  localparam int DATA_READ_RAZR = 9;
  localparam int LENTH_BUFER    = 1 << DATA_READ_RAZR;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWAP   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_FINISH = 3'd5
  } drain_state_t;

endpackage

// File: rtl/buf_spi_drain_spi_tx_shift.sv
// rtl/buf_spi_drain_spi_tx_shift.sv - SPI mode-0 SCK divider, bit counter and shifter with holding-register reload
module spi_tx_shift
  import buf_spi_drain_pkg::*;
#(
  parameter int DATA_W  = SPI_WIDHT,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK2,
  input  logic              RESET,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] hold_data,
  input  logic              more,
  output logic              SCK,
  output logic              MOSI,
  output logic              reload,
  output logic              last_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              active;
  logic              half_end;
  logic              fall;
  logic              last_bit;

  // A falling SCK edge on the last bit either chains the next byte or ends the frame
  assign half_end  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall      = half_end && SCK;
  assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
  assign reload    = fall && last_bit && more;
  assign last_fall = fall && last_bit && !more;

  // SCK half-period divider; MOSI only moves on the falling edge so it is stable at every rise
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
    end else if (load) begin
      shreg   <= load_data;
      MOSI    <= load_data[DATA_W-1];
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      SCK     <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        SCK     <= ~SCK;
        if (SCK) begin
          if (!last_bit) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            MOSI    <= shreg[DATA_W-2];
            bit_cnt <= bit_cnt + BIT_W'(1);
          end else if (more) begin
            shreg   <= hold_data;
            MOSI    <= hold_data[DATA_W-1];
            bit_cnt <= '0;
          end else begin
            active  <= 1'b0;
            MOSI    <= 1'b0;
            bit_cnt <= '0;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/buf_spi_drain.sv
// rtl/buf_spi_drain.sv - drains one ping-pong buffer bank as a single SPI mode-0 master frame
module buf_spi_drain
  import buf_spi_drain_pkg::*;
#(
  parameter int DATA_W  = FSMC_WIDTH,
  parameter int ADDR_W  = DATA_READ_RAZR,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK2,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] LENGTH,
  output logic [ADDR_W-1:0] NUMB_BYTE_OUT,
  input  logic [DATA_W-1:0] DATA_OUT,
  output logic              BUFER_CHANGE,
  output logic              SCK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              BUSY,
  output logic              DONE
);

  drain_state_t      state;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] byte_idx;
  logic [DATA_W-1:0] hold_r;
  logic [1:0]        cap_pipe;
  logic              fetch_cnt;
  logic [ADDR_W:0]   byte_next;
  logic [ADDR_W:0]   addr_next;
  logic              more;
  logic              addr_adv;
  logic              issue_addr;
  logic              tx_load;
  logic              reload;
  logic              last_fall;

  // Widened compares so a LENGTH at the top of the address range cannot wrap
  assign byte_next  = {1'b0, byte_idx} + (ADDR_W + 1)'(1);
  assign addr_next  = {1'b0, NUMB_BYTE_OUT} + (ADDR_W + 1)'(1);
  assign more       = byte_next < {1'b0, len_r};
  assign addr_adv   = addr_next < {1'b0, len_r};
  assign tx_load    = (state == ST_LOAD);
  assign issue_addr = addr_adv && (tx_load || ((state == ST_SHIFT) && reload));

  spi_tx_shift #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .CLK2      (CLK2),
    .RESET     (RESET),
    .load      (tx_load),
    .load_data (DATA_OUT),
    .hold_data (hold_r),
    .more      (more),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .reload    (reload),
    .last_fall (last_fall)
  );

  // Frame FSM: bank swap, read-latency wait, first load, then prefetch one byte ahead until the last bit
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      len_r         <= '0;
      byte_idx      <= '0;
      hold_r        <= '0;
      cap_pipe      <= '0;
      fetch_cnt     <= 1'b0;
      NUMB_BYTE_OUT <= '0;
      BUFER_CHANGE  <= 1'b0;
      CS_N          <= 1'b1;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      cap_pipe <= {cap_pipe[0], issue_addr};
      if (cap_pipe[1]) begin
        hold_r <= DATA_OUT;
      end
      if (issue_addr) begin
        NUMB_BYTE_OUT <= addr_next[ADDR_W-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (START) begin
            len_r <= LENGTH;
            BUSY  <= 1'b1;
            state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          BUFER_CHANGE  <= ~BUFER_CHANGE;
          NUMB_BYTE_OUT <= '0;
          fetch_cnt     <= 1'b0;
          state         <= (len_r == '0) ? ST_FINISH : ST_FETCH;
        end
        ST_FETCH: begin
          fetch_cnt <= 1'b1;
          if (fetch_cnt) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          CS_N     <= 1'b0;
          byte_idx <= '0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (reload) begin
            byte_idx <= byte_next[ADDR_W-1:0];
          end
          if (last_fall) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          CS_N  <= 1'b1;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_spi_drain.sv
// tb/tb_buf_spi_drain.sv - scoreboard bench for buf_spi_drain with buffer and SPI slave models
module tb_buf_spi_drain;

  localparam int CLK_DIV = 4;

  logic       CLK2;
  logic       RESET;
  logic       START;
  logic [8:0] LENGTH;
  logic [8:0] NUMB_BYTE_OUT;
  logic [7:0] DATA_OUT;
  logic       BUFER_CHANGE;
  logic       SCK;
  logic       MOSI;
  logic       CS_N;
  logic       BUSY;
  logic       DONE;

  buf_spi_drain #(
    .DATA_W  (8),
    .ADDR_W  (9),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .CLK2          (CLK2),
    .RESET         (RESET),
    .START         (START),
    .LENGTH        (LENGTH),
    .NUMB_BYTE_OUT (NUMB_BYTE_OUT),
    .DATA_OUT      (DATA_OUT),
    .BUFER_CHANGE  (BUFER_CHANGE),
    .SCK           (SCK),
    .MOSI          (MOSI),
    .CS_N          (CS_N),
    .BUSY          (BUSY),
    .DONE          (DONE)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1][0:511];
  logic [7:0] exp_q [$];
  logic       bank_model;

  logic [7:0] rx_sh;
  int         rx_bits;
  int         sck_rises;
  int         bad_runs;
  int         run_len;
  int         done_cnt;
  int         bc_toggles;
  int         max_addr;
  int         csn_low_seen;
  logic       prev_sck;
  logic       prev_csn;
  logic       prev_bc;

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Buffer model: registered read, bank picked by BUFER_CHANGE
  always @(posedge CLK2) DATA_OUT <= mem[BUFER_CHANGE][NUMB_BYTE_OUT];

  // SPI slave and protocol monitor, sampled between active edges
  always @(negedge CLK2) begin
    logic [31:0] exp_b;
    if (RESET) begin
      rx_bits  = 0;
      run_len  = 0;
      prev_sck = SCK;
      prev_csn = CS_N;
      prev_bc  = BUFER_CHANGE;
    end else begin
      if (DONE) done_cnt++;
      if (BUFER_CHANGE !== prev_bc) bc_toggles++;
      if (BUSY && (int'(NUMB_BYTE_OUT) > max_addr)) max_addr = int'(NUMB_BYTE_OUT);
      if (!CS_N) csn_low_seen = 1;
      if (SCK && !prev_sck) begin
        sck_rises++;
        if (!CS_N) begin
          rx_sh = {rx_sh[6:0], MOSI};
          rx_bits++;
          if (rx_bits == 8) begin
            rx_bits = 0;
            exp_b = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
            check("rx_byte", 32'(rx_sh), exp_b);
          end
        end
      end
      if (!CS_N) begin
        if (prev_csn) run_len = 1;
        else if (SCK == prev_sck) run_len++;
        else begin
          if (run_len != CLK_DIV) bad_runs++;
          run_len = 1;
        end
      end
      prev_sck = SCK;
      prev_csn = CS_N;
      prev_bc  = BUFER_CHANGE;
    end
  end

  task automatic tick();
    @(posedge CLK2);
    #1;
  endtask

  task automatic clr_stats();
    sck_rises    = 0;
    bad_runs     = 0;
    bc_toggles   = 0;
    max_addr     = 0;
    csn_low_seen = 0;
  endtask

  task automatic start_frame(input int len);
    bank_model = ~bank_model;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[bank_model][i]);
    START  = 1'b1;
    LENGTH = 9'(len);
    tick();
    START  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(DONE), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    RESET      = 1'b1;
    START      = 1'b0;
    LENGTH     = '0;
    bank_model = 1'b0;
    done_cnt   = 0;
    rx_sh      = '0;
    rx_bits    = 0;
    run_len    = 0;
    clr_stats();
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 8'(8'h40 + i);
      mem[1][i] = 8'(8'h60 + i);
    end
    mem[1][0] = 8'hA5;
    mem[1][1] = 8'h3C;
    mem[1][2] = 8'hFF;

    repeat (3) @(posedge CLK2);
    #3 RESET = 1'b0;
    repeat (20) tick();
    check("rst_csn", 32'(CS_N), 32'd1);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_bc", 32'(BUFER_CHANGE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_addr", 32'(NUMB_BYTE_OUT), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);

    // Three-byte frame from bank 1
    clr_stats();
    d0 = done_cnt;
    start_frame(3);
    check("t1_bc_e0", 32'(BUFER_CHANGE), 32'd0);
    check("t1_busy", 32'(BUSY), 32'd1);
    tick();
    check("t1_bc_e1", 32'(BUFER_CHANGE), 32'd1);
    tick();
    tick();
    check("t1_csn_e3", 32'(CS_N), 32'd1);
    tick();
    check("t1_csn_e4", 32'(CS_N), 32'd0);
    wait_done("t1");
    check("t1_busy_end", 32'(BUSY), 32'd0);
    tick();
    check("t1_csn_end", 32'(CS_N), 32'd1);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_rises", 32'(sck_rises), 32'd24);
    check("t1_runs", 32'(bad_runs), 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_max_addr", 32'(max_addr), 32'd2);
    check("t1_toggles", 32'(bc_toggles), 32'd1);

    // Zero-length frame
    clr_stats();
    d0 = done_cnt;
    start_frame(0);
    tick();
    check("t2_bc_e1", 32'(BUFER_CHANGE), 32'd0);
    check("t2_done_e1", 32'(DONE), 32'd0);
    tick();
    check("t2_done_e2", 32'(DONE), 32'd1);
    repeat (3) tick();
    check("t2_csn_low", 32'(csn_low_seen), 32'd0);
    check("t2_rises", 32'(sck_rises), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_toggles", 32'(bc_toggles), 32'd1);

    // Reset in the middle of byte 1
    clr_stats();
    d0 = done_cnt;
    start_frame(3);
    begin
      int cyc;
      cyc = 0;
      while (sck_rises < 10 && cyc < 2000) begin
        tick();
        cyc++;
      end
      check("t4_reach_byte1", 32'(sck_rises >= 10), 32'd1);
    end
    check("t4_bc_pre", 32'(BUFER_CHANGE), 32'd1);
    check("t4_csn_pre", 32'(CS_N), 32'd0);
    #2 RESET = 1'b1;
    #1;
    check("t4_csn_async", 32'(CS_N), 32'd1);
    check("t4_sck_async", 32'(SCK), 32'd0);
    check("t4_bc_async", 32'(BUFER_CHANGE), 32'd0);
    check("t4_busy_async", 32'(BUSY), 32'd0);
    exp_q.delete();
    bank_model = 1'b0;
    @(posedge CLK2);
    @(posedge CLK2);
    #3 RESET = 1'b0;
    repeat (5) tick();
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    clr_stats();
    mem[1][0] = 8'h81;
    start_frame(1);
    wait_done("t4b");
    tick();
    check("t4b_rises", 32'(sck_rises), 32'd8);
    check("t4b_q_empty", 32'(exp_q.size()), 32'd0);
    check("t4b_runs", 32'(bad_runs), 32'd0);
    check("t4b_bc", 32'(BUFER_CHANGE), 32'd1);
    check("t4b_max_addr", 32'(max_addr), 32'd0);

    // Second START while a two-byte frame is active
    clr_stats();
    d0 = done_cnt;
    start_frame(2);
    repeat (20) tick();
    START  = 1'b1;
    LENGTH = 9'd5;
    tick();
    START  = 1'b0;
    wait_done("t3");
    tick();
    check("t3_rises", 32'(sck_rises), 32'd16);
    check("t3_toggles", 32'(bc_toggles), 32'd1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    check("t3_bc", 32'(BUFER_CHANGE), 32'd0);
    check("t3_max_addr", 32'(max_addr), 32'd1);
    repeat (10) tick();
    check("t3_idle_busy", 32'(BUSY), 32'd0);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Back-to-back frames, START the cycle after DONE
    clr_stats();
    d0 = done_cnt;
    mem[1][0] = 8'hC3;
    mem[1][1] = 8'h5A;
    mem[0][0] = 8'h0F;
    mem[0][1] = 8'hF0;
    start_frame(2);
    tick();
    check("t5_bc_f1", 32'(BUFER_CHANGE), 32'd1);
    wait_done("t5a");
    start_frame(2);
    tick();
    check("t5_bc_f2", 32'(BUFER_CHANGE), 32'd0);
    wait_done("t5b");
    tick();
    check("t5_rises", 32'(sck_rises), 32'd32);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    check("t5_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("t5_toggles", 32'(bc_toggles), 32'd2);
    check("t5_runs", 32'(bad_runs), 32'd0);
    check("t5_max_addr", 32'(max_addr), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
